periph_dispatcher: RTL and testbench
====================================

Name: periph_dispatcher

Overview:
- Downstream (host-to-DUT) router; the counterpart of the upstream arbiter/mux path.
- Pops 32-bit packets from the ftdi_to_lycan FIFO (first-word-fall-through) and decodes the 3-bit peripheral address in the header.
- Presents each packet to exactly one peripheral's tx port, with per-peripheral backpressure.
- Replaces the current broadcast of tx_data/tx_valid. Packets for not-ready peripherals, and packets that stall too long, are dropped and counted.

Parameters:
- NUM_PERIPHERALS, 8, number of peripheral tx ports; must equal 2**ADDR_WIDTH.
- ADDR_WIDTH, 3, width of the address field.
- STALL_TIMEOUT, 1024, cycles a packet may wait on a full peripheral before it is dropped; 0 = never drop.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  FT601-supplied clock.
- rst  in  1  Asynchronous, active-high reset.
- enable  in  1  When 0, no new FIFO pops; a packet already held still resolves.
- fifo_dout  in  32  FWFT data from ftdi_to_lycan FIFO.
- fifo_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  Pop strobe; combinational.
- periph_ready  in  NUM_PERIPHERALS  Per-peripheral ready.
- periph_tx_full  in  NUM_PERIPHERALS  Per-peripheral tx FIFO full.
- periph_tx_data  out  32  Held packet, broadcast to all peripherals.
- periph_tx_valid  out  NUM_PERIPHERALS  One-hot write strobe.
- fwd_count  out  CNT_WIDTH  Packets delivered.
- drop_count  out  CNT_WIDTH  Packets dropped because the target was not ready.
- timeout_count  out  CNT_WIDTH  Packets dropped by stall timeout.
- busy  out  1  A packet is held.

Behaviour:
- Header address is addr = hold[31:29] (lycan_globals packet format); bits [28:0] are opaque.
- States:
  - IDLE: hold empty.
  - HOLD: hold_reg valid.
- Reset (async): state=IDLE, hold_reg=0, stall_cnt=0, all counters=0. Consequently periph_tx_valid=0, fifo_rd_en=0, busy=0.
- Combinational terms:
  - deliver = HOLD & periph_ready[addr] & ~periph_tx_full[addr]
  - nr_drop = HOLD & ~periph_ready[addr]
  - to_drop = HOLD & periph_ready[addr] & periph_tx_full[addr] & (STALL_TIMEOUT!=0) & (stall_cnt==STALL_TIMEOUT-1)
  - resolve = deliver | nr_drop | to_drop
- fifo_rd_en = enable & ~fifo_empty & (IDLE | resolve).
  - On fifo_rd_en, hold_reg <= fifo_dout, state <= HOLD, stall_cnt <= 0.
  - This allows back-to-back packets at 1 per cycle.
- HOLD with resolve and no pop -> IDLE.
- HOLD, target ready but full, no timeout: stall_cnt++ and stay in HOLD. Head-of-line blocking is intentional, preserving global order.
- periph_tx_valid[i] = deliver & (addr==i); otherwise 0. Combinational from registered state only; it never depends on fifo_dout.
- periph_tx_data = hold_reg, registered.
- Latency: FIFO non-empty to tx_valid is 1 cycle when the target can accept.
- Counters:
  - fwd_count +1 on deliver, drop_count +1 on nr_drop, timeout_count +1 on to_drop.
  - All saturate at all-ones; no wrap.
- periph_ready is sampled in every HOLD cycle. If the target de-asserts ready mid-stall, the packet drops that cycle as nr_drop.
- enable=0 while in HOLD: the held packet still delivers or drops; the state then goes to IDLE and no pop occurs.
- fifo_empty=1 at a resolve cycle: go to IDLE with no pop.
- busy = (state==HOLD).

Decomposition:
- lycan_globals gains:
  - PKT_ADDR_MSB=31 and PKT_ADDR_LSB=29 constants.
  - typedef periph_addr_t (logic [2:0]).
  - The existing usb_packet_width and num_peripherals constants are reused for the defaults.
- One sub-module: sat_counter (WIDTH, inc -> count, saturating), instantiated three times.
- The existing decoder may generate the one-hot valid.

Test Plan:
1. Reset, then FIFO holds 0x2000_00AA (addr 1), all ready, none full -> fifo_rd_en pulses 1 cycle; next cycle periph_tx_valid=8'b0000_0010, periph_tx_data=0x2000_00AA; fwd_count=1.
2. Four back-to-back packets to addr 0,7,3,3, no backpressure -> 4 consecutive cycles of one-hot valid 0x01,0x80,0x08,0x08; fifo_rd_en high 4 consecutive cycles; fwd_count=4.
3. Packet to addr 5 with periph_tx_full[5]=1 for 10 cycles, then 0 -> valid[5] asserted on cycle 11 after capture; no pops during stall; busy=1 throughout the stall.
4. STALL_TIMEOUT=16, addr 2 held full forever -> packet dropped after exactly 16 HOLD cycles; timeout_count=1; next packet popped that same cycle; valid never asserted.
5. periph_ready[4]=0, send a packet to addr 4 and then to addr 1 -> first is dropped (drop_count=1) with no valid; second delivered one cycle later with valid=0x02.
6. Assert rst while holding a stalled packet, and set CNT_WIDTH=4 with 20 deliveries -> after reset all outputs are 0 and busy=0; fwd_count saturates at 15.

Source files
------------

// File: rtl/periph_dispatcher_pkg.sv
// Packet-format constants and types shared by the downstream peripheral dispatcher.
package periph_dispatcher_pkg;

    localparam int usb_packet_width = 32;
    localparam int num_peripherals  = 8;
    localparam int PKT_ADDR_MSB     = 31;
    localparam int PKT_ADDR_LSB     = 29;

    typedef logic [PKT_ADDR_MSB-PKT_ADDR_LSB:0] periph_addr_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } disp_state_t;

endpackage

// File: rtl/periph_dispatcher_sat_counter.sv
// Saturating event counter: counts i_inc pulses, sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count register with saturation at the maximum value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/periph_dispatcher.sv
// Downstream router: pops FWFT packets and strobes exactly one peripheral tx port,
// dropping packets whose target is not ready or stays full past the stall timeout.
module periph_dispatcher
    import periph_dispatcher_pkg::*;
#(
    parameter int NUM_PERIPHERALS = num_peripherals,
    parameter int ADDR_WIDTH      = $bits(periph_addr_t),
    parameter int STALL_TIMEOUT   = 1024,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [usb_packet_width-1:0] fifo_dout,
    input  logic                        fifo_empty,
    output logic                        fifo_rd_en,
    input  logic [NUM_PERIPHERALS-1:0]  periph_ready,
    input  logic [NUM_PERIPHERALS-1:0]  periph_tx_full,
    output logic [usb_packet_width-1:0] periph_tx_data,
    output logic [NUM_PERIPHERALS-1:0]  periph_tx_valid,
    output logic [CNT_WIDTH-1:0]        fwd_count,
    output logic [CNT_WIDTH-1:0]        drop_count,
    output logic [CNT_WIDTH-1:0]        timeout_count,
    output logic                        busy
);

    localparam int                 STALL_W      = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam int                 STALL_LAST_I = (STALL_TIMEOUT > 0) ? (STALL_TIMEOUT - 1) : 0;
    localparam logic [STALL_W-1:0] STALL_LAST   = STALL_W'(STALL_LAST_I);
    localparam logic               TIMEOUT_EN   = (STALL_TIMEOUT != 0);

    disp_state_t                 r_state;
    disp_state_t                 w_next_state;
    logic [usb_packet_width-1:0] r_hold;
    logic [STALL_W-1:0]          r_stall_cnt;
    logic [ADDR_WIDTH-1:0]       w_addr;
    logic                        w_holding;
    logic                        w_tgt_ready;
    logic                        w_tgt_full;
    logic                        w_deliver;
    logic                        w_nr_drop;
    logic                        w_to_drop;
    logic                        w_resolve;
    logic                        w_pop;

    assign w_addr = r_hold[PKT_ADDR_MSB -: ADDR_WIDTH];

    // Resolution terms and next-state; a pop is blocked while rst is high so no word is lost
    always_comb begin
        w_holding   = (r_state == ST_HOLD);
        w_tgt_ready = periph_ready[w_addr];
        w_tgt_full  = periph_tx_full[w_addr];
        w_deliver   = w_holding & w_tgt_ready & ~w_tgt_full;
        w_nr_drop   = w_holding & ~w_tgt_ready;
        w_to_drop   = w_holding & w_tgt_ready & w_tgt_full & TIMEOUT_EN
                      & (r_stall_cnt == STALL_LAST);
        w_resolve   = w_deliver | w_nr_drop | w_to_drop;
        w_pop       = enable & ~fifo_empty & ~rst & (~w_holding | w_resolve);

        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) w_next_state = ST_HOLD;
                else       w_next_state = ST_IDLE;
            end
            ST_HOLD: begin
                if (w_pop)          w_next_state = ST_HOLD;
                else if (w_resolve) w_next_state = ST_IDLE;
                else                w_next_state = ST_HOLD;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, held packet and stall counter; a pop always restarts the stall count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pop) begin
                r_hold      <= fifo_dout;
                r_stall_cnt <= '0;
            end else if (w_holding && !w_resolve) begin
                r_stall_cnt <= r_stall_cnt + STALL_W'(1);
            end
        end
    end

    // One-hot write strobe decoded from the held header only
    always_comb begin
        periph_tx_valid = '0;
        if (w_deliver) periph_tx_valid[w_addr] = 1'b1;
        else           periph_tx_valid = '0;
    end

    assign fifo_rd_en     = w_pop;
    assign periph_tx_data = r_hold;
    assign busy           = w_holding;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_fwd_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_deliver),
        .o_count (fwd_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_nr_drop),
        .o_count (drop_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_to_drop),
        .o_count (timeout_count)
    );

endmodule

// File: tb/tb_periph_dispatcher.sv
// Directed bench for periph_dispatcher: a vector table for steady-state routing plus
// hand-written stall, timeout, enable, reset and saturation sequences.
module tb_periph_dispatcher;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [31:0]   fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [7:0]    periph_ready;
    logic [7:0]    periph_tx_full;
    logic [31:0]   periph_tx_data;
    logic [7:0]    periph_tx_valid;
    logic [CW-1:0] fwd_count;
    logic [CW-1:0] drop_count;
    logic [CW-1:0] timeout_count;
    logic          busy;

    always #5 clk = ~clk;

    periph_dispatcher #(
        .NUM_PERIPHERALS (8),
        .ADDR_WIDTH      (3),
        .STALL_TIMEOUT   (16),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .fifo_dout       (fifo_dout),
        .fifo_empty      (fifo_empty),
        .fifo_rd_en      (fifo_rd_en),
        .periph_ready    (periph_ready),
        .periph_tx_full  (periph_tx_full),
        .periph_tx_data  (periph_tx_data),
        .periph_tx_valid (periph_tx_valid),
        .fwd_count       (fwd_count),
        .drop_count      (drop_count),
        .timeout_count   (timeout_count),
        .busy            (busy)
    );

    typedef struct {
        logic          do_rst;
        logic          push;
        logic [31:0]   pkt;
        logic [7:0]    rdy;
        logic [7:0]    full;
        logic          en;
        logic          e_rd;
        logic [7:0]    e_valid;
        logic [31:0]   e_data;
        logic          e_busy;
        logic [CW-1:0] e_fwd;
        logic [CW-1:0] e_drop;
        logic [CW-1:0] e_to;
    } vec_t;

    vec_t        vt [10];
    logic [31:0] q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        obs_rd;
    logic        obs_busy;
    logic [7:0]  obs_valid;
    logic [31:0] obs_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample combinational outputs mid-cycle, pop the model FIFO after the edge.
    task automatic tick(input logic [7:0] rdy, input logic [7:0] full, input logic en);
        @(negedge clk);
        periph_ready   = rdy;
        periph_tx_full = full;
        enable         = en;
        fifo_empty     = (q.size() == 0);
        fifo_dout      = (q.size() != 0) ? q[0] : 32'h0;
        #2;
        obs_rd    = fifo_rd_en;
        obs_busy  = busy;
        obs_valid = periph_tx_valid;
        obs_data  = periph_tx_data;
        @(posedge clk);
        #1;
        if (obs_rd && (q.size() != 0)) void'(q.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_valid", periph_tx_valid, 32'h0);
        chk("rst_rd_en", fifo_rd_en, 32'h0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_data", periph_tx_data, 32'h0);
        chk("rst_fwd", fwd_count, 32'h0);
        chk("rst_drop", drop_count, 32'h0);
        chk("rst_timeout", timeout_count, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        fifo_empty = 1'b1;
        fifo_dout  = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        enable         = 1'b0;
        fifo_empty     = 1'b1;
        fifo_dout      = 32'h0;
        periph_ready   = 8'h00;
        periph_tx_full = 8'h00;

        // Back-to-back to addr 0,7,3,3, then addr-4 not-ready drop followed by addr-1 delivery
        vt[0] = '{1'b1, 1'b1, 32'h0000_0001, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 32'h0000_0000, 1'b0, 4'd0, 4'd0, 4'd0};
        vt[1] = '{1'b0, 1'b1, 32'hE000_0007, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h01, 32'h0000_0001, 1'b1, 4'd1, 4'd0, 4'd0};
        vt[2] = '{1'b0, 1'b1, 32'h6000_0003, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h80, 32'hE000_0007, 1'b1, 4'd2, 4'd0, 4'd0};
        vt[3] = '{1'b0, 1'b1, 32'h6000_0033, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h08, 32'h6000_0003, 1'b1, 4'd3, 4'd0, 4'd0};
        vt[4] = '{1'b0, 1'b0, 32'h0000_0000, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h08, 32'h6000_0033, 1'b1, 4'd4, 4'd0, 4'd0};
        vt[5] = '{1'b0, 1'b0, 32'h0000_0000, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 32'h6000_0033, 1'b0, 4'd4, 4'd0, 4'd0};
        vt[6] = '{1'b1, 1'b1, 32'h8000_0004, 8'hEF, 8'h00, 1'b1, 1'b1, 8'h00, 32'h0000_0000, 1'b0, 4'd0, 4'd0, 4'd0};
        vt[7] = '{1'b0, 1'b1, 32'h2000_0001, 8'hEF, 8'h00, 1'b1, 1'b1, 8'h00, 32'h8000_0004, 1'b1, 4'd0, 4'd1, 4'd0};
        vt[8] = '{1'b0, 1'b0, 32'h0000_0000, 8'hEF, 8'h00, 1'b1, 1'b0, 8'h02, 32'h2000_0001, 1'b1, 4'd1, 4'd1, 4'd0};
        vt[9] = '{1'b0, 1'b0, 32'h0000_0000, 8'hEF, 8'h00, 1'b1, 1'b0, 8'h00, 32'h2000_0001, 1'b0, 4'd1, 4'd1, 4'd0};

        repeat (2) @(negedge clk);
        do_reset();

        // Single packet to addr 1
        q.push_back(32'h2000_00AA);
        tick(8'hFF, 8'h00, 1'b1);
        chk("t1_rd_en", obs_rd, 32'h1);
        chk("t1_valid_pre", obs_valid, 32'h0);
        tick(8'hFF, 8'h00, 1'b1);
        chk("t1_valid", obs_valid, 32'h02);
        chk("t1_data", obs_data, 32'h2000_00AA);
        chk("t1_rd_off", obs_rd, 32'h0);
        chk("t1_fwd", fwd_count, 32'h1);
        tick(8'hFF, 8'h00, 1'b1);
        chk("t1_idle", obs_busy, 32'h0);

        for (int i = 0; i < 10; i++) begin
            if (vt[i].do_rst) do_reset();
            if (vt[i].push) q.push_back(vt[i].pkt);
            tick(vt[i].rdy, vt[i].full, vt[i].en);
            chk($sformatf("vec%0d_rd_en", i), obs_rd, vt[i].e_rd);
            chk($sformatf("vec%0d_valid", i), obs_valid, vt[i].e_valid);
            chk($sformatf("vec%0d_data", i), obs_data, vt[i].e_data);
            chk($sformatf("vec%0d_busy", i), obs_busy, vt[i].e_busy);
            chk($sformatf("vec%0d_fwd", i), fwd_count, vt[i].e_fwd);
            chk($sformatf("vec%0d_drop", i), drop_count, vt[i].e_drop);
            chk($sformatf("vec%0d_timeout", i), timeout_count, vt[i].e_to);
        end

        // Addr 5 full for 10 HOLD cycles, delivered on the 11th with the next packet popped
        do_reset();
        q.push_back(32'hA000_0005);
        tick(8'hFF, 8'h20, 1'b1);
        chk("t3_capture", obs_rd, 32'h1);
        q.push_back(32'h2000_0011);
        for (int k = 1; k <= 10; k++) begin
            tick(8'hFF, 8'h20, 1'b1);
            chk($sformatf("t3_stall%0d_valid", k), obs_valid, 32'h0);
            chk($sformatf("t3_stall%0d_rd_en", k), obs_rd, 32'h0);
            chk($sformatf("t3_stall%0d_busy", k), obs_busy, 32'h1);
        end
        tick(8'hFF, 8'h00, 1'b1);
        chk("t3_valid", obs_valid, 32'h20);
        chk("t3_data", obs_data, 32'hA000_0005);
        chk("t3_pop", obs_rd, 32'h1);
        chk("t3_fwd", fwd_count, 32'h1);
        tick(8'hFF, 8'h00, 1'b1);
        chk("t3_next_valid", obs_valid, 32'h02);
        chk("t3_fwd2", fwd_count, 32'h2);

        // Addr 2 full forever: dropped on the 16th HOLD cycle, next packet popped then
        do_reset();
        q.push_back(32'h4000_0002);
        q.push_back(32'h2000_0022);
        tick(8'hFF, 8'h04, 1'b1);
        for (int k = 1; k <= 15; k++) begin
            tick(8'hFF, 8'h04, 1'b1);
            chk($sformatf("t4_stall%0d_valid", k), obs_valid, 32'h0);
            chk($sformatf("t4_stall%0d_rd_en", k), obs_rd, 32'h0);
        end
        tick(8'hFF, 8'h04, 1'b1);
        chk("t4_drop_valid", obs_valid, 32'h0);
        chk("t4_drop_pop", obs_rd, 32'h1);
        chk("t4_timeout", timeout_count, 32'h1);
        chk("t4_fwd0", fwd_count, 32'h0);
        tick(8'hFF, 8'h04, 1'b1);
        chk("t4_next_valid", obs_valid, 32'h02);
        chk("t4_next_data", obs_data, 32'h2000_0022);

        // Target loses ready mid-stall: not-ready drop
        q.push_back(32'h4000_0002);
        tick(8'hFF, 8'h04, 1'b1);
        repeat (3) tick(8'hFF, 8'h04, 1'b1);
        tick(8'hFB, 8'h04, 1'b1);
        chk("t5b_valid", obs_valid, 32'h0);
        chk("t5b_drop", drop_count, 32'h1);
        tick(8'hFF, 8'h00, 1'b1);
        chk("t5b_idle", obs_busy, 32'h0);

        // enable low while holding: held packet resolves, no new pop
        q.push_back(32'h2000_0044);
        q.push_back(32'h2000_0055);
        tick(8'hFF, 8'h02, 1'b1);
        tick(8'hFF, 8'h02, 1'b0);
        chk("en_stall_busy", obs_busy, 32'h1);
        tick(8'hFF, 8'h00, 1'b0);
        chk("en_deliver", obs_valid, 32'h02);
        chk("en_no_pop", obs_rd, 32'h0);
        tick(8'hFF, 8'h00, 1'b0);
        chk("en_idle_busy", obs_busy, 32'h0);
        chk("en_idle_rd", obs_rd, 32'h0);
        tick(8'hFF, 8'h00, 1'b1);
        chk("en_resume_pop", obs_rd, 32'h1);
        tick(8'hFF, 8'h00, 1'b1);
        chk("en_resume_data", obs_data, 32'h2000_0055);
        chk("en_fwd", fwd_count, 32'h3);

        // Reset while stalled with a non-empty FIFO and enable high
        q.push_back(32'hA000_0005);
        q.push_back(32'h2000_0066);
        tick(8'hFF, 8'h20, 1'b1);
        tick(8'hFF, 8'h20, 1'b1);
        chk("t6_pre_busy", obs_busy, 32'h1);
        do_reset();

        // 20 deliveries saturate the 4-bit forward counter
        for (int k = 0; k < 20; k++) begin
            q.push_back(32'h0000_0100 + 32'(k));
            tick(8'hFF, 8'h00, 1'b1);
        end
        tick(8'hFF, 8'h00, 1'b1);
        tick(8'hFF, 8'h00, 1'b1);
        chk("sat_fwd", fwd_count, 32'hF);
        chk("sat_busy", obs_busy, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
